// File: rtl/spreading_factors_pkg.sv
// spreading_factors_pkg: shared DCSK spreading-factor encodings, constants and helpers
package spreading_factors_pkg;

    localparam int WORD_BITS  = 32;
    localparam int CHIP_W_DEF = 8;

    typedef enum logic [1:0] {
        SF2  = 2'd0,
        SF4  = 2'd1,
        SF8  = 2'd2,
        SF16 = 2'd3
    } sf_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RUN   = 2'd3
    } mapper_state_t;

    // Chips per half-slot for a spreading factor code: 2, 4, 8 or 16.
    function automatic logic [4:0] sf_half(input logic [1:0] sf);
        return 5'd2 << sf;
    endfunction

    // Two's complement negation that clamps the most negative value to the most positive.
    function automatic logic [CHIP_W_DEF-1:0] sat_neg(input logic [CHIP_W_DEF-1:0] x);
        return (x == {1'b1, {(CHIP_W_DEF-1){1'b0}}}) ? {1'b0, {(CHIP_W_DEF-1){1'b1}}} : -x;
    endfunction

endpackage

// File: rtl/dcsk_ref_buf.sv
// dcsk_ref_buf: 16-entry reference chip store, synchronous write, asynchronous read
module dcsk_ref_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         we_i,
    input  logic [3:0]   waddr_i,
    input  logic [W-1:0] wdata_i,
    input  logic [3:0]   raddr_i,
    output logic [W-1:0] rdata_o
);

    logic [W-1:0] mem_q [16];

    // Capture reference-half samples; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dcsk_chip_mapper.sv
// dcsk_chip_mapper: maps message bits onto DCSK chips using buffered chaotic reference samples
module dcsk_chip_mapper
    import spreading_factors_pkg::*;
#(
    parameter int CHIP_W = CHIP_W_DEF,
    parameter int WORD_W = WORD_BITS
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic [1:0]        i_spreading_factor,
    input  logic [WORD_W-1:0] i_data_word,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic              o_send,
    input  logic              i_sending,
    input  logic [4:0]        i_chip_index,
    input  logic              i_msb,
    input  logic              i_load_bit,
    input  logic [CHIP_W-1:0] i_chaos_data,
    input  logic              i_chaos_empty,
    output logic              o_chaos_rd,
    output logic [CHIP_W-1:0] o_chip,
    output logic              o_chip_valid,
    output logic              o_underrun
);

    mapper_state_t     state_q;
    logic [WORD_W-1:0] shreg_q;
    logic              rdy_q, send_q, vld_q, urun_q;
    logic [CHIP_W-1:0] chip_q, chip_d, rd_data, wr_data;
    logic [4:0]        half_m1;
    logic [3:0]        idx;
    logic              run_c, ref_c, dat_c, unused_ok;

    assign half_m1   = sf_half(i_spreading_factor) - 5'd1;
    assign idx       = i_chip_index[3:0] & half_m1[3:0];
    assign unused_ok = i_chip_index[4] | half_m1[4];
    // Gating with i_sending keeps the trailing RUN cycle from popping an extra sample.
    assign run_c      = (state_q == RUN) & i_sending;
    assign ref_c      = run_c & ~i_msb;
    assign dat_c      = run_c & i_msb;
    assign wr_data    = i_chaos_empty ? '0 : i_chaos_data;
    assign o_chaos_rd = ref_c & ~i_chaos_empty;

    dcsk_ref_buf #(.W(CHIP_W)) u_ref_buf (
        .clk_i   (i_clk),
        .we_i    (ref_c),
        .waddr_i (idx),
        .wdata_i (wr_data),
        .raddr_i (idx),
        .rdata_o (rd_data)
    );

    // Reference half passes the sample through; data half replays it, negated for a 1 bit.
    always_comb chip_d = ref_c ? wr_data : dat_c ? (shreg_q[0] ? sat_neg(rd_data) : rd_data) : '0;

    // Handshake FSM with registered outputs, bit shifter and sticky underrun flag.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            rdy_q   <= 1'b0;
            send_q  <= 1'b0;
            vld_q   <= 1'b0;
            urun_q  <= 1'b0;
            chip_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rdy_q && i_data_valid) begin
                        shreg_q <= i_data_word;
                        urun_q  <= 1'b0;
                        send_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                        state_q <= START;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                START: begin
                    send_q  <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: if (i_sending) state_q <= RUN;
                default: begin
                    if (i_load_bit) shreg_q <= shreg_q >> 1;
                    if (!i_sending) begin
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
            if (ref_c && i_chaos_empty) urun_q <= 1'b1;
            vld_q  <= run_c;
            chip_q <= chip_d;
        end
    end

    assign o_data_ready = rdy_q;
    assign o_send       = send_q;
    assign o_chip       = chip_q;
    assign o_chip_valid = vld_q;
    assign o_underrun   = urun_q;

endmodule
